hipass_reader: RTL
==================

# hipass_reader

Upstream front end of the toll-gate path: receives the serial frame sent by a vehicle's hipass on-board unit and delivers the 4-bit card code `hipass_out` that the gate controller (`top`) consumes. It synchronises the serial line, checks frame format and even parity, and presents each good code as a short pulse. Outside a pulse, `hipass_out` is 0 ("no card").

## Interface
- `BIT_CYCLES`, 4: clock cycles per serial bit; even, ≥4.
- `HOLD_CYCLES`, 2: cycles a decoded code is held on `hipass_out`; ≥1.
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `rx` input 1: serial line from the on-board unit; idles high; asynchronous to `clk`.
- `hipass_out` output 4: decoded card code; 0 when no valid code is being presented.
- `frame_err` output 1: one-cycle pulse on a rejected frame.

## Operation
- Frame, LSB first: start (0), d0..d3, parity p, stop (1). Total 7 bit times. Parity is even: d0^d1^d2^d3^p must be 0.
- `rx` passes through a 2-flop synchroniser to give `rx_s`. All decoding below uses `rx_s`.
- States: IDLE, START, DATA, PARITY, STOP, HOLD, WAIT_IDLE.
- IDLE: if `rx_s`=0, go to START and clear the bit-timer.
- START: at BIT_CYCLES/2 cycles, sample `rx_s`.
  - 0: go to DATA and restart the bit-timer.
  - 1: treat as a glitch and return to IDLE. No `frame_err`.
- DATA: every BIT_CYCLES, sample one bit into a shift register, d0 first. After d3, go to PARITY.
- PARITY: after BIT_CYCLES, sample p and go to STOP.
- STOP: after BIT_CYCLES, sample the stop bit.
  - Stop=1 and parity OK: load `hipass_out` with d3..d0 and go to HOLD.
  - Stop=1 and parity bad: pulse `frame_err`, return to IDLE.
  - Stop=0: pulse `frame_err`, go to WAIT_IDLE.
- HOLD: keep `hipass_out` for HOLD_CYCLES cycles, then drive 0 and go to IDLE. `rx_s` is ignored during HOLD.
- WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. Prevents a stuck-low line from retriggering.
- A good frame whose code is 0000 yields `hipass_out`=0 for the hold window. It is indistinguishable from no card, which is intended.
- Bit-timer width is clog2(BIT_CYCLES). Hold counter width is clog2(HOLD_CYCLES+1).

## Timing
- Reset values: `hipass_out`=0, `frame_err`=0, state=IDLE, synchroniser flops=1, counters=0, shift register=0.
- `rst` asserted mid-frame or mid-HOLD aborts at once. Outputs go to reset values with no `frame_err` pulse.
- Synchroniser latency: `rx_s` follows `rx` by 2 clock edges.
- Let T0 be the edge at which IDLE sees `rx_s`=0. Sample edges:
  - start: T0+BIT_CYCLES/2
  - d(i): T0+BIT_CYCLES/2+(i+1)·BIT_CYCLES
  - p: +5·BIT_CYCLES
  - stop: +6·BIT_CYCLES
- `hipass_out` and `frame_err` are registered at the stop-sample edge. They are visible from the next cycle.
- `hipass_out` is nonzero for exactly HOLD_CYCLES cycles.
- After HOLD, IDLE is re-entered. A new start can be detected on the following edge.
- Back-to-back frames need no gap beyond the stop bit plus HOLD_CYCLES.

## Test plan
- Good frame, code 1110: bits 0,1,1,1 then p=1, stop=1, with BIT_CYCLES=4 and HOLD_CYCLES=2.
  - `hipass_out`=4'b1110 for exactly 2 cycles starting 2+2+24+1 edges after `rx` falls, then 0.
  - `frame_err` stays 0.
- Good frame, code 0100: bits 0,0,1,0, p=1.
  - `hipass_out`=4'b0100 for 2 cycles.
  - Immediately afterwards, a second frame for 1110 decodes correctly.
- Parity error: code 1110 sent with p=0.
  - `frame_err` is high for one cycle at the stop-sample edge.
  - `hipass_out` stays 0.
- Glitch: `rx` low for 1 cycle, then high.
  - No output and no `frame_err`; the FSM returns to IDLE.
  - A following good frame decodes.
- Stop error with stuck line: stop bit 0 and `rx` held low for 20 more cycles.
  - Exactly one `frame_err` pulse, then no further activity until `rx` rises.
  - The next good frame decodes.
- Reset mid-frame: assert `rst` during d2.
  - Outputs go to 0 immediately.
  - After release with `rx` high, a fresh good frame decodes normally.

Source files
------------

// File: rtl/hipass_reader.sv
// Serial front end for the toll gate: synchronises rx, decodes a
// start/4-data/even-parity/stop frame and pulses the card code on hipass_out.
module hipass_reader #(
  parameter int BIT_CYCLES  = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] hipass_out,
  output logic       frame_err
);

  localparam int TW = $clog2(BIT_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(BIT_CYCLES / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(BIT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, HOLD, WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, rx_s_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    bitcnt_q, bitcnt_d;
  logic [3:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    out_q, out_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      hold_q   <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= rx;
      rx_s_q   <= sync1_q;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      hold_q   <= hold_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    hold_d   = hold_q;
    out_d    = out_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == HALF_M1) begin
          timer_d  = '0;
          bitcnt_d = '0;
          state_d  = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == FULL_M1) begin
          // d0 enters first and ends up in bit 0 after four shifts
          timer_d  = '0;
          shift_d  = {rx_s_q, shift_q[3:1]};
          bitcnt_d = bitcnt_q + 2'd1;
          if (bitcnt_q == 2'd3) state_d = PARITY;
        end
      end
      PARITY: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          par_d   = rx_s_q;
          state_d = STOP;
        end
      end
      STOP: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          if (!rx_s_q) begin
            err_d   = 1'b1;
            state_d = WAIT_IDLE;
          end else if (^{shift_q, par_q}) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            out_d   = shift_q;
            hold_d  = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HOLD_M1) begin
          out_d   = '0;
          state_d = IDLE;
        end
      end
      WAIT_IDLE: begin
        // a stuck-low line must rise before a new start is accepted
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign hipass_out = out_q;
  assign frame_err  = err_q;

endmodule
